// File: rtl/cpu_exec_scheduler.sv
// Execution scheduler: dispatches one issued instruction to the ALU, MD, MEM or BR unit,
// waits for that unit's done (guarded by a watchdog) and returns a single registered commit.
module cpu_exec_scheduler #(
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned CNT_W       = 16
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         issue_i,
  input  logic [4:0]   opcode_i,
  input  logic [31:0]  op0_i,
  input  logic [31:0]  op1_i,
  input  logic [18:0]  jump_addr_i,
  input  logic [18:0]  pc_i,
  input  logic         div_mult_i,
  input  logic         sign_i,
  output logic [3:0]   unit_start_o,
  output logic [4:0]   unit_opcode_o,
  output logic [31:0]  unit_op0_o,
  output logic [31:0]  unit_op1_o,
  output logic [18:0]  unit_jump_addr_o,
  output logic [18:0]  unit_pc_o,
  output logic         unit_div_mult_o,
  output logic         unit_sign_o,
  input  logic [3:0]   unit_done_i,
  input  logic [127:0] unit_data_i,
  output logic         commit_o,
  output logic [31:0]  return_data_o,
  output logic [3:0]   byte_o,
  output logic         busy_o,
  output logic         err_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_RESP
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  // One-hot unit lane for an opcode; zero marks the opcodes the scheduler ignores.
  function automatic logic [3:0] classify(input logic [4:0] op);
    logic [3:0] cls;
    case (op)
      5'd0, 5'd1, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9:                 cls = 4'b0001;
      5'd2, 5'd3:                                               cls = 4'b0010;
      5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21, 5'd22,
      5'd24, 5'd25, 5'd26, 5'd27, 5'd28, 5'd29, 5'd30:          cls = 4'b0100;
      5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15:                 cls = 4'b1000;
      default:                                                  cls = 4'b0000;
    endcase
    return cls;
  endfunction

  function automatic logic [3:0] byte_enables(input logic [4:0] op, input logic [3:0] lane);
    logic [3:0] be;
    be = 4'h0;
    if (lane[0] || lane[1]) begin
      be = 4'hF;
    end else if (lane[2]) begin
      case (op)
        5'd24:   be = 4'h1;
        5'd25:   be = 4'h2;
        5'd26:   be = 4'h4;
        5'd27:   be = 4'h8;
        5'd28:   be = 4'h3;
        5'd29:   be = 4'hC;
        5'd30:   be = 4'hF;
        default: be = 4'h0;
      endcase
    end
    return be;
  endfunction

  state_e      state_q, state_d;
  logic [3:0]  lane_q, lane_d;
  logic [4:0]  opcode_q, opcode_d;
  logic [31:0] op0_q, op0_d;
  logic [31:0] op1_q, op1_d;
  logic [18:0] jump_q, jump_d;
  logic [18:0] pc_q, pc_d;
  logic        div_mult_q, div_mult_d;
  logic        sign_q, sign_d;
  logic [3:0]  start_q, start_d;
  logic        commit_q, commit_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  byte_q, byte_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [3:0]  issue_cls;
  logic [3:0]  stray_done;
  logic        active_done;
  logic [31:0] lane_data;

  assign issue_cls   = classify(opcode_i);
  assign stray_done  = unit_done_i & ~lane_q;
  assign active_done = |(unit_done_i & lane_q);

  always_comb begin
    lane_data = 32'h0;
    for (int k = 0; k < 4; k++) begin
      if (lane_q[k]) begin
        lane_data = unit_data_i[32*k +: 32];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    lane_d     = lane_q;
    opcode_d   = opcode_q;
    op0_d      = op0_q;
    op1_d      = op1_q;
    jump_d     = jump_q;
    pc_d       = pc_q;
    div_mult_d = div_mult_q;
    sign_d     = sign_q;
    start_d    = 4'b0000;
    commit_d   = 1'b0;
    data_d     = data_q;
    byte_d     = byte_q;
    err_d      = err_q;
    cnt_d      = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (|unit_done_i) begin
          err_d = 1'b1;
        end
        if (issue_i && (|issue_cls)) begin
          lane_d     = issue_cls;
          opcode_d   = opcode_i;
          op0_d      = op0_i;
          op1_d      = op1_i;
          jump_d     = jump_addr_i;
          pc_d       = pc_i;
          div_mult_d = div_mult_i;
          sign_d     = sign_i;
          start_d    = issue_cls;
          state_d    = S_START;
        end
      end

      S_START: begin
        cnt_d = '0;
        if (issue_i || (|stray_done)) begin
          err_d = 1'b1;
        end
        // A unit may finish in the same cycle it is started.
        if (active_done) begin
          data_d   = lane_data;
          byte_d   = byte_enables(opcode_q, lane_q);
          commit_d = 1'b1;
          state_d  = S_RESP;
        end else begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (issue_i || (|stray_done)) begin
          err_d = 1'b1;
        end
        if (active_done) begin
          data_d   = lane_data;
          byte_d   = byte_enables(opcode_q, lane_q);
          commit_d = 1'b1;
          state_d  = S_RESP;
        end else if (cnt_d == CNT_LAST) begin
          data_d   = 32'h0;
          byte_d   = 4'h0;
          commit_d = 1'b1;
          err_d    = 1'b1;
          state_d  = S_RESP;
        end
      end

      S_RESP: begin
        if (issue_i || (|stray_done)) begin
          err_d = 1'b1;
        end
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      lane_q     <= 4'b0000;
      opcode_q   <= 5'd0;
      op0_q      <= 32'h0;
      op1_q      <= 32'h0;
      jump_q     <= 19'h0;
      pc_q       <= 19'h0;
      div_mult_q <= 1'b0;
      sign_q     <= 1'b0;
      start_q    <= 4'b0000;
      commit_q   <= 1'b0;
      data_q     <= 32'h0;
      byte_q     <= 4'h0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      lane_q     <= lane_d;
      opcode_q   <= opcode_d;
      op0_q      <= op0_d;
      op1_q      <= op1_d;
      jump_q     <= jump_d;
      pc_q       <= pc_d;
      div_mult_q <= div_mult_d;
      sign_q     <= sign_d;
      start_q    <= start_d;
      commit_q   <= commit_d;
      data_q     <= data_d;
      byte_q     <= byte_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign unit_start_o     = start_q;
  assign unit_opcode_o    = opcode_q;
  assign unit_op0_o       = op0_q;
  assign unit_op1_o       = op1_q;
  assign unit_jump_addr_o = jump_q;
  assign unit_pc_o        = pc_q;
  assign unit_div_mult_o  = div_mult_q;
  assign unit_sign_o      = sign_q;
  assign commit_o         = commit_q;
  assign return_data_o    = data_q;
  assign byte_o           = byte_q;
  assign busy_o           = busy_q;
  assign err_o            = err_q;

endmodule

// File: tb/tb_cpu_exec_scheduler.sv
// Scoreboard bench for cpu_exec_scheduler: directed scenarios plus randomized traffic,
// with expected starts/commits queued at stimulus time and checked by an independent monitor.
module tb_cpu_exec_scheduler;

  localparam int TIMEOUT = 12;

  logic         clk;
  logic         resetn;
  logic         issue_i;
  logic [4:0]   opcode_i;
  logic [31:0]  op0_i;
  logic [31:0]  op1_i;
  logic [18:0]  jump_addr_i;
  logic [18:0]  pc_i;
  logic         div_mult_i;
  logic         sign_i;
  logic [3:0]   unit_start_o;
  logic [4:0]   unit_opcode_o;
  logic [31:0]  unit_op0_o;
  logic [31:0]  unit_op1_o;
  logic [18:0]  unit_jump_addr_o;
  logic [18:0]  unit_pc_o;
  logic         unit_div_mult_o;
  logic         unit_sign_o;
  logic [3:0]   unit_done_i;
  logic [127:0] unit_data_i;
  logic         commit_o;
  logic [31:0]  return_data_o;
  logic [3:0]   byte_o;
  logic         busy_o;
  logic         err_o;

  cpu_exec_scheduler #(.TIMEOUT_CYC(TIMEOUT), .CNT_W(16)) dut (
    .clk              (clk),
    .resetn           (resetn),
    .issue_i          (issue_i),
    .opcode_i         (opcode_i),
    .op0_i            (op0_i),
    .op1_i            (op1_i),
    .jump_addr_i      (jump_addr_i),
    .pc_i             (pc_i),
    .div_mult_i       (div_mult_i),
    .sign_i           (sign_i),
    .unit_start_o     (unit_start_o),
    .unit_opcode_o    (unit_opcode_o),
    .unit_op0_o       (unit_op0_o),
    .unit_op1_o       (unit_op1_o),
    .unit_jump_addr_o (unit_jump_addr_o),
    .unit_pc_o        (unit_pc_o),
    .unit_div_mult_o  (unit_div_mult_o),
    .unit_sign_o      (unit_sign_o),
    .unit_done_i      (unit_done_i),
    .unit_data_i      (unit_data_i),
    .commit_o         (commit_o),
    .return_data_o    (return_data_o),
    .byte_o           (byte_o),
    .busy_o           (busy_o),
    .err_o            (err_o)
  );

  typedef struct {
    logic [3:0]  lane;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [18:0] jump;
    logic [18:0] pc;
    int          cyc;
  } start_t;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  be;
    int          cyc;
  } commit_t;

  start_t  startQ[$];
  commit_t commitQ[$];
  start_t  monStart;
  commit_t monCommit;

  int   nCompared   = 0;
  int   nMismatched = 0;
  int   cyc         = 0;
  logic expErr      = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference classification: lane index per opcode group, -1 for ignored opcodes.
  function automatic int expLane(input logic [4:0] op);
    int v;
    v = int'(op);
    if (v == 4 || v == 23 || v == 31) return -1;
    if (v == 2 || v == 3) return 1;
    if (v <= 9) return 0;
    if (v <= 15) return 3;
    return 2;
  endfunction

  function automatic logic [3:0] expByte(input logic [4:0] op);
    int v;
    v = int'(op);
    if (v <= 9 && v != 4) return 4'hF;
    if (v >= 24 && v <= 27) return 4'(1 << (v - 24));
    if (v == 28) return 4'h3;
    if (v == 29) return 4'hC;
    if (v == 30) return 4'hF;
    return 4'h0;
  endfunction

  // Monitor: every start or commit the DUT presents must match the next queued expectation.
  always @(negedge clk) begin
    if (unit_start_o != 4'b0000) begin
      if (startQ.size() == 0) begin
        checkOutput("unexpectedStart", 32'(unit_start_o), 32'h0);
      end else begin
        monStart = startQ.pop_front();
        checkOutput("startLane", 32'(unit_start_o), 32'(monStart.lane));
        checkOutput("startCycle", cyc, monStart.cyc);
        checkOutput("startOpcode", 32'(unit_opcode_o), 32'(monStart.op));
        checkOutput("startOp0", unit_op0_o, monStart.a);
        checkOutput("startOp1", unit_op1_o, monStart.b);
        checkOutput("startJump", 32'(unit_jump_addr_o), 32'(monStart.jump));
        checkOutput("startPc", 32'(unit_pc_o), 32'(monStart.pc));
        checkOutput("startBusy", 32'(busy_o), 32'h1);
      end
    end
    if (commit_o) begin
      if (commitQ.size() == 0) begin
        checkOutput("unexpectedCommit", 32'(commit_o), 32'h0);
      end else begin
        monCommit = commitQ.pop_front();
        checkOutput("commitData", return_data_o, monCommit.data);
        checkOutput("commitByte", 32'(byte_o), 32'(monCommit.be));
        checkOutput("commitCycle", cyc, monCommit.cyc);
      end
    end
  end

  task automatic doReset();
    tick();
    #2;
    resetn      = 1'b0;
    issue_i     = 1'b0;
    unit_done_i = 4'b0000;
    startQ.delete();
    commitQ.delete();
    expErr = 1'b0;
    #1;
    checkOutput("rstStart", 32'(unit_start_o), 32'h0);
    checkOutput("rstCommit", 32'(commit_o), 32'h0);
    checkOutput("rstBusy", 32'(busy_o), 32'h0);
    checkOutput("rstErr", 32'(err_o), 32'h0);
    checkOutput("rstOpcode", 32'(unit_opcode_o), 32'h0);
    checkOutput("rstOp0", unit_op0_o, 32'h0);
    checkOutput("rstData", return_data_o, 32'h0);
    checkOutput("rstByte", 32'(byte_o), 32'h0);
    repeat (2) @(posedge clk);
    #3;
    resetn = 1'b1;
    tick();
  endtask

  // One instruction: delay = cycle offset of the active done from issue (0 = never, forcing
  // the watchdog); strayMask fires at strayAt; busyAt re-issues while the op is in flight.
  task automatic applyStimulus(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                               input int delay, input logic [31:0] res,
                               input logic [3:0] strayMask, input int strayAt, input int busyAt);
    int          lane;
    int          n;
    int          maxT;
    int          guard;
    logic [3:0]  oh;
    logic [127:0] bus;
    start_t      s;
    commit_t     c;
    lane = expLane(op);
    tick();
    issue_i     = 1'b1;
    opcode_i    = op;
    op0_i       = a;
    op1_i       = b;
    jump_addr_i = 19'($urandom);
    pc_i        = 19'($urandom);
    div_mult_i  = 1'($urandom);
    sign_i      = 1'($urandom);
    n = cyc;
    if (lane < 0) begin
      tick();
      issue_i = 1'b0;
      checkOutput("ignoredBusy", 32'(busy_o), 32'h0);
      return;
    end
    oh     = 4'(1 << lane);
    s.lane = oh;
    s.op   = op;
    s.a    = a;
    s.b    = b;
    s.jump = jump_addr_i;
    s.pc   = pc_i;
    s.cyc  = n + 1;
    startQ.push_back(s);
    if (delay == 0) begin
      c.data = 32'h0;
      c.be   = 4'h0;
      c.cyc  = n + 1 + TIMEOUT;
      commitQ.push_back(c);
      expErr = 1'b1;
    end
    tick();
    issue_i = 1'b0;
    maxT = (delay > strayAt) ? delay : strayAt;
    if (busyAt > maxT) maxT = busyAt;
    for (int t = 1; t <= maxT; t++) begin
      bus = {$urandom, $urandom, $urandom, $urandom};
      bus[32*lane +: 32] = res;
      unit_data_i = bus;
      unit_done_i = ((t == delay) ? oh : 4'b0000) | ((t == strayAt) ? strayMask : 4'b0000);
      if (t == delay) begin
        c.data = res;
        c.be   = expByte(op);
        c.cyc  = n + t + 1;
        commitQ.push_back(c);
      end
      if (t == strayAt && strayMask != 4'b0000) expErr = 1'b1;
      if (t == busyAt) begin
        issue_i  = 1'b1;
        opcode_i = 5'd1;
        expErr   = 1'b1;
      end
      tick();
      issue_i     = 1'b0;
      unit_done_i = 4'b0000;
    end
    guard = 0;
    while ((commitQ.size() != 0 || startQ.size() != 0) && guard < TIMEOUT + 20) begin
      tick();
      guard++;
    end
    if (commitQ.size() != 0 || startQ.size() != 0) begin
      checkOutput("responseMissing", 32'(commitQ.size() + startQ.size()), 32'h0);
      commitQ.delete();
      startQ.delete();
    end
    checkOutput("errFlag", 32'(err_o), 32'(expErr));
  endtask

  logic [4:0] ignOps [3];

  initial begin
    #1000000;
    $display("[TB] FAIL globalTimeout: simulation did not finish, expected completion");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    resetn      = 1'b0;
    issue_i     = 1'b0;
    opcode_i    = 5'd0;
    op0_i       = 32'h0;
    op1_i       = 32'h0;
    jump_addr_i = 19'h0;
    pc_i        = 19'h0;
    div_mult_i  = 1'b0;
    sign_i      = 1'b0;
    unit_done_i = 4'b0000;
    unit_data_i = 128'h0;
    ignOps[0] = 5'd4;
    ignOps[1] = 5'd23;
    ignOps[2] = 5'd31;
    $display("[TB] start");
    doReset();

    applyStimulus(5'd0, 32'd5, 32'd7, 2, 32'h0000000C, 4'b0000, 0, 0);
    applyStimulus(5'd26, $urandom, $urandom, 11, 32'h00AB0000, 4'b0000, 0, 0);
    applyStimulus(5'd29, $urandom, $urandom, 11, 32'hBEEF0000, 4'b0000, 0, 0);
    applyStimulus(5'd30, $urandom, $urandom, 1, 32'h89ABCDEF, 4'b0000, 0, 0);

    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("ignBusy", 32'(busy_o), 32'h0);
      issue_i  = 1'b1;
      opcode_i = ignOps[i];
    end
    tick();
    issue_i = 1'b0;
    checkOutput("ignBusy", 32'(busy_o), 32'h0);
    tick();
    checkOutput("ignBusy", 32'(busy_o), 32'h0);

    applyStimulus(5'd3, $urandom, $urandom, 0, 32'h0, 4'b0000, 0, 0);

    doReset();
    applyStimulus(5'd10, $urandom, $urandom, 4, 32'h00001234, 4'b0001, 2, 0);
    applyStimulus(5'd0, $urandom, $urandom, 3, 32'h55AA55AA, 4'b0000, 0, 1);

    doReset();
    tick();
    issue_i     = 1'b1;
    opcode_i    = 5'd2;
    op0_i       = 32'h00000011;
    op1_i       = 32'h00000022;
    monStart.lane = 4'b0010;
    monStart.op   = 5'd2;
    monStart.a    = op0_i;
    monStart.b    = op1_i;
    monStart.jump = jump_addr_i;
    monStart.pc   = pc_i;
    monStart.cyc  = cyc + 1;
    startQ.push_back(monStart);
    tick();
    issue_i = 1'b0;
    tick();
    tick();
    checkOutput("mdBusyWait", 32'(busy_o), 32'h1);
    doReset();
    applyStimulus(5'd1, $urandom, $urandom, 3, 32'hCAFEF00D, 4'b0000, 0, 0);

    tick();
    unit_done_i = 4'b0100;
    expErr      = 1'b1;
    tick();
    unit_done_i = 4'b0000;
    checkOutput("idleDoneErr", 32'(err_o), 32'(expErr));

    doReset();
    for (int i = 0; i < 40; i++) begin
      logic [4:0] op;
      int         d;
      int         lane;
      logic [3:0] stray;
      int         strayAt;
      op      = 5'($urandom_range(0, 31));
      d       = $urandom_range(0, TIMEOUT);
      lane    = expLane(op);
      stray   = 4'b0000;
      strayAt = 0;
      if (lane >= 0 && $urandom_range(0, 5) == 0) begin
        stray   = 4'($urandom_range(1, 15)) & ~4'(1 << lane);
        strayAt = $urandom_range(1, (d == 0) ? TIMEOUT - 1 : d);
      end
      applyStimulus(op, $urandom, $urandom, d, $urandom, stray, strayAt, 0);
    end

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
